// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator: 8-bit linear level that ramps through
// attack/decay/sustain/release. Its speed is set by a shared prescaler
// tick and a per-state rate counter.
module adsr_envelope_gen #(
    parameter int PRESCALE_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gate,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    output logic [7:0] envelope_value,
    output logic [2:0] env_state,
    output logic       env_active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    state_t        r_state;
    logic [7:0]    r_level;
    logic [7:0]    r_rate_cnt;
    logic [PW-1:0] r_presc;
    logic          r_gate_d;

    logic       w_tick;
    logic [7:0] w_rate;
    logic       w_rate_hit;
    logic       w_step;
    logic       w_rise;
    logic       w_fall;

    assign w_tick     = (r_presc == PW'(PRESCALE_DIV - 1));
    assign w_rate_hit = (r_rate_cnt == w_rate);
    assign w_step     = w_tick & w_rate_hit;
    assign w_rise     = gate & ~r_gate_d;
    assign w_fall     = ~gate & r_gate_d;

    // Select the rate register belonging to the current state.
    // IDLE and SUSTAIN have no rate, so the counter idles at 0 there.
    always_comb begin
        w_rate = 8'd0;
        case (r_state)
            S_ATTACK:  w_rate = attack_rate;
            S_DECAY:   w_rate = decay_rate;
            S_RELEASE: w_rate = release_rate;
            default:   w_rate = 8'd0;
        endcase
    end

    // Free-running prescaler and the gate delay used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_gate_d <= 1'b0;
        end else begin
            r_presc  <= w_tick ? '0 : r_presc + 1'b1;
            r_gate_d <= gate;
        end
    end

    // Envelope FSM. Priority is gate edge, then the level-limit
    // transition, then the step. Every transition clears the rate counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_level    <= 8'h00;
            r_rate_cnt <= 8'h00;
        end else begin
            // The rate counter wraps 255 -> 0 when a live rate edit drops
            // the rate below the current count.
            if (w_tick)
                r_rate_cnt <= w_rate_hit ? 8'h00 : r_rate_cnt + 8'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state    <= S_ATTACK;
                        r_rate_cnt <= 8'h00;
                    end else begin
                        r_level <= 8'h00;
                    end
                end
                S_ATTACK: begin
                    if (w_fall) begin
                        r_state    <= S_RELEASE;
                        r_rate_cnt <= 8'h00;
                    end else if (r_level == 8'hFF) begin
                        r_state    <= S_DECAY;
                        r_rate_cnt <= 8'h00;
                    end else if (w_step) begin
                        r_level <= r_level + 8'd1;
                    end
                end
                S_DECAY: begin
                    if (w_fall) begin
                        r_state    <= S_RELEASE;
                        r_rate_cnt <= 8'h00;
                    end else if (r_level <= sustain_level) begin
                        r_state    <= S_SUSTAIN;
                        r_rate_cnt <= 8'h00;
                    end else if (w_step) begin
                        r_level <= r_level - 8'd1;
                    end
                end
                S_SUSTAIN: begin
                    if (w_fall) begin
                        r_state    <= S_RELEASE;
                        r_rate_cnt <= 8'h00;
                    end else begin
                        r_level <= sustain_level;
                    end
                end
                S_RELEASE: begin
                    if (w_rise) begin
                        r_state    <= S_ATTACK;
                        r_rate_cnt <= 8'h00;
                    end else if (r_level == 8'h00) begin
                        r_state    <= S_IDLE;
                        r_rate_cnt <= 8'h00;
                    end else if (w_step) begin
                        r_level <= r_level - 8'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_level    <= 8'h00;
                    r_rate_cnt <= 8'h00;
                end
            endcase
        end
    end

    assign envelope_value = r_level;
    assign env_state      = r_state;
    assign env_active     = (r_state != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Directed bench for adsr_envelope_gen. One instance runs with a tick every
// cycle; a second instance with a /4 prescaler shares the same inputs.
module tb_adsr_envelope_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gate = 1'b0;
    logic [7:0] attack_rate = 8'd0;
    logic [7:0] decay_rate = 8'd0;
    logic [7:0] sustain_level = 8'h80;
    logic [7:0] release_rate = 8'd0;

    logic [7:0] ev1, ev4;
    logic [2:0] st1, st4;
    logic       act1, act4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    adsr_envelope_gen #(.PRESCALE_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .envelope_value(ev1), .env_state(st1), .env_active(act1)
    );

    adsr_envelope_gen #(.PRESCALE_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .envelope_value(ev4), .env_state(st4), .env_active(act4)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        gate  = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        attack_rate = 0; decay_rate = 0; release_rate = 0; sustain_level = 8'h80;
        gate = 1'b0; rst_n = 1'b0;
        cyc(2);
        n_total++; if (ev1 !== 8'h00) $display("FAIL reset_level got=%h exp=00", ev1); else n_pass++;
        n_total++; if (st1 !== 3'd0) $display("FAIL reset_state got=%0d exp=0", st1); else n_pass++;
        n_total++; if (act1 !== 1'b0) $display("FAIL reset_active got=%b exp=0", act1); else n_pass++;
        n_total++; if (st4 !== 3'd0) $display("FAIL reset_state4 got=%0d exp=0", st4); else n_pass++;
        rst_n = 1'b1;
        cyc(5);
        n_total++; if (st1 !== 3'd0 || ev1 !== 8'h00) $display("FAIL idle_hold st=%0d lvl=%h exp 0/00", st1, ev1); else n_pass++;
        gate = 1'b1;
        cyc(1);
        n_total++; if (st1 !== 3'd1) $display("FAIL rise_attack got=%0d exp=1", st1); else n_pass++;
        cyc(10);
        n_total++; if (ev1 !== 8'd10) $display("FAIL attack_ramp got=%h exp=0a", ev1); else n_pass++;
        // asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (ev1 !== 8'h00 || st1 !== 3'd0 || act1 !== 1'b0)
            $display("FAIL async_reset lvl=%h st=%0d act=%b exp 00/0/0", ev1, st1, act1); else n_pass++;
        cyc(1);
        n_total++; if (ev1 !== 8'h00 || st1 !== 3'd0) $display("FAIL reset_held lvl=%h st=%0d", ev1, st1); else n_pass++;
        rst_n = 1'b1;  // gate still high: first edge is a rise
        cyc(1);
        n_total++; if (st1 !== 3'd1 || ev1 !== 8'h00) $display("FAIL post_reset_rise st=%0d lvl=%h exp 1/00", st1, ev1); else n_pass++;
        gate = 1'b0;
        cyc(1);
        n_total++; if (st1 !== 3'd4) $display("FAIL fall_release got=%0d exp=4", st1); else n_pass++;
        cyc(1);
        n_total++; if (st1 !== 3'd0) $display("FAIL release_zero_idle got=%0d exp=0", st1); else n_pass++;
    endtask

    task automatic test_full_cycle();
        attack_rate = 0; decay_rate = 0; release_rate = 0; sustain_level = 8'h80;
        do_reset();
        gate = 1'b1;
        cyc(1);
        n_total++; if (st1 !== 3'd1 || ev1 !== 8'h00) $display("FAIL fc_attack st=%0d lvl=%h exp 1/00", st1, ev1); else n_pass++;
        cyc(255);
        n_total++; if (ev1 !== 8'hFF || st1 !== 3'd1) $display("FAIL fc_peak lvl=%h st=%0d exp ff/1", ev1, st1); else n_pass++;
        cyc(1);
        n_total++; if (st1 !== 3'd2 || ev1 !== 8'hFF) $display("FAIL fc_decay st=%0d lvl=%h exp 2/ff", st1, ev1); else n_pass++;
        cyc(127);
        n_total++; if (ev1 !== 8'h80 || st1 !== 3'd2) $display("FAIL fc_decay_end lvl=%h st=%0d exp 80/2", ev1, st1); else n_pass++;
        cyc(1);
        n_total++; if (st1 !== 3'd3 || ev1 !== 8'h80) $display("FAIL fc_sustain st=%0d lvl=%h exp 3/80", st1, ev1); else n_pass++;
        cyc(200);
        n_total++; if (st1 !== 3'd3 || ev1 !== 8'h80) $display("FAIL fc_sustain_hold st=%0d lvl=%h exp 3/80", st1, ev1); else n_pass++;
        gate = 1'b0;
        cyc(1);
        n_total++; if (st1 !== 3'd4 || ev1 !== 8'h80) $display("FAIL fc_release st=%0d lvl=%h exp 4/80", st1, ev1); else n_pass++;
        cyc(128);
        n_total++; if (ev1 !== 8'h00 || st1 !== 3'd4) $display("FAIL fc_release_end lvl=%h st=%0d exp 00/4", ev1, st1); else n_pass++;
        cyc(1);
        n_total++; if (st1 !== 3'd0 || act1 !== 1'b0) $display("FAIL fc_idle st=%0d act=%b exp 0/0", st1, act1); else n_pass++;
    endtask

    task automatic test_rate_scaling();
        attack_rate = 8'd2; decay_rate = 0; release_rate = 0; sustain_level = 8'h80;
        do_reset();
        gate = 1'b1;
        cyc(11);
        n_total++; if (ev4 !== 8'd0 || st4 !== 3'd1) $display("FAIL rs_before lvl=%h st=%0d exp 00/1", ev4, st4); else n_pass++;
        cyc(1);
        n_total++; if (ev4 !== 8'd1) $display("FAIL rs_step1 got=%h exp=01", ev4); else n_pass++;
        cyc(11);
        n_total++; if (ev4 !== 8'd1) $display("FAIL rs_hold got=%h exp=01", ev4); else n_pass++;
        cyc(1);
        n_total++; if (ev4 !== 8'd2) $display("FAIL rs_step2 got=%h exp=02", ev4); else n_pass++;
        cyc(12);
        n_total++; if (ev4 !== 8'd3) $display("FAIL rs_step3 got=%h exp=03", ev4); else n_pass++;
    endtask

    task automatic test_early_release();
        attack_rate = 0; decay_rate = 0; release_rate = 0; sustain_level = 8'h80;
        do_reset();
        gate = 1'b1;
        cyc(65);
        n_total++; if (ev1 !== 8'h40) $display("FAIL er_level got=%h exp=40", ev1); else n_pass++;
        gate = 1'b0;
        cyc(1);
        n_total++; if (st1 !== 3'd4 || ev1 !== 8'h40) $display("FAIL er_release st=%0d lvl=%h exp 4/40", st1, ev1); else n_pass++;
        cyc(1);
        n_total++; if (ev1 !== 8'h3F) $display("FAIL er_decrement got=%h exp=3f", ev1); else n_pass++;
    endtask

    task automatic test_retrigger();
        attack_rate = 0; decay_rate = 0; release_rate = 0; sustain_level = 8'h80;
        do_reset();
        gate = 1'b1;
        cyc(49);
        gate = 1'b0;
        cyc(1);
        n_total++; if (st1 !== 3'd4 || ev1 !== 8'h30) $display("FAIL rt_release st=%0d lvl=%h exp 4/30", st1, ev1); else n_pass++;
        release_rate = 8'd2;   // counter goes nonzero without stepping
        cyc(1);
        gate = 1'b1;
        attack_rate = 8'd3;
        cyc(1);
        n_total++; if (st1 !== 3'd1 || ev1 !== 8'h30) $display("FAIL rt_attack st=%0d lvl=%h exp 1/30", st1, ev1); else n_pass++;
        cyc(3);
        n_total++; if (ev1 !== 8'h30) $display("FAIL rt_cnt_cleared got=%h exp=30", ev1); else n_pass++;
        cyc(1);
        n_total++; if (ev1 !== 8'h31) $display("FAIL rt_first_step got=%h exp=31", ev1); else n_pass++;
    endtask

    task automatic test_boundaries();
        attack_rate = 0; decay_rate = 0; release_rate = 0; sustain_level = 8'hFF;
        do_reset();
        gate = 1'b1;
        cyc(256);
        n_total++; if (ev1 !== 8'hFF || st1 !== 3'd1) $display("FAIL bd_peak lvl=%h st=%0d exp ff/1", ev1, st1); else n_pass++;
        cyc(1);
        n_total++; if (st1 !== 3'd2) $display("FAIL bd_decay got=%0d exp=2", st1); else n_pass++;
        cyc(1);
        n_total++; if (st1 !== 3'd3 || ev1 !== 8'hFF) $display("FAIL bd_sus_ff st=%0d lvl=%h exp 3/ff", st1, ev1); else n_pass++;
        sustain_level = 8'h80;
        cyc(1);
        n_total++; if (ev1 !== 8'h80) $display("FAIL bd_sus_80 got=%h exp=80", ev1); else n_pass++;
        sustain_level = 8'h20;
        cyc(1);
        n_total++; if (ev1 !== 8'h20) $display("FAIL bd_sus_20 got=%h exp=20", ev1); else n_pass++;
        sustain_level = 8'h00;
        cyc(1);
        n_total++; if (ev1 !== 8'h00 || st1 !== 3'd3) $display("FAIL bd_sus_00 lvl=%h st=%0d exp 00/3", ev1, st1); else n_pass++;
        gate = 1'b0;
        cyc(1);
        n_total++; if (st1 !== 3'd4) $display("FAIL bd_rel0 got=%0d exp=4", st1); else n_pass++;
        cyc(1);
        n_total++; if (st1 !== 3'd0) $display("FAIL bd_rel0_idle got=%0d exp=0", st1); else n_pass++;
        // single-cycle gate pulse
        sustain_level = 8'h80;
        do_reset();
        gate = 1'b1;
        cyc(1);
        gate = 1'b0;
        n_total++; if (st1 !== 3'd1) $display("FAIL bd_pulse_attack got=%0d exp=1", st1); else n_pass++;
        cyc(1);
        n_total++; if (st1 !== 3'd4) $display("FAIL bd_pulse_release got=%0d exp=4", st1); else n_pass++;
        // rate lowered below the running count: counter wraps before matching
        attack_rate = 8'd5;
        do_reset();
        gate = 1'b1;
        cyc(5);
        attack_rate = 8'd2;
        cyc(254);
        n_total++; if (ev1 !== 8'h00) $display("FAIL bd_wrap_wait got=%h exp=00", ev1); else n_pass++;
        cyc(1);
        n_total++; if (ev1 !== 8'h01) $display("FAIL bd_wrap_step got=%h exp=01", ev1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_rate_scaling();
        test_early_release();
        test_retrigger();
        test_boundaries();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
